// File: rtl/fair_round_monitor.sv
// fair_round_monitor
//   Degeneralizes the generalized-Buechi acceptance of the upstream property
//   automaton into a round tracker. While the automaton stays in its
//   accepting SCC, the monitor waits for fair[0], fair[1], ... fair[NFAIR-1]
//   in index order. Each full pass is one round. It also reports starvation
//   (too long in the SCC without completing a round) and any SCC exit.
//
// Ports
//   clock       in   posedge clock
//   reset       in   asynchronous, active-high
//   step        in   sample enable; state holds when 0 (round_done clears)
//   scc         in   automaton state lies in the accepting SCC
//   fair        in   [NFAIR-1:0] fairness outputs of the automaton
//   idx         out  [IDXW-1:0] fairness set currently awaited
//   round_done  out  one-cycle pulse per completed round
//   rounds      out  [CNTW-1:0] completed rounds, saturating
//   starve      out  age reached STARVE_LIMIT in the current round
//   scc_exit    out  sticky: scc fell 1->0 at least once
//   in_scc      out  registered copy of scc
module fair_round_monitor #(
  parameter int NFAIR        = 4,
  parameter int IDXW         = 2,
  parameter int CNTW         = 8,
  parameter int AGEW         = 7,
  parameter int STARVE_LIMIT = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             step,
  input  logic             scc,
  input  logic [NFAIR-1:0] fair,
  output logic [IDXW-1:0]  idx,
  output logic             round_done,
  output logic [CNTW-1:0]  rounds,
  output logic             starve,
  output logic             scc_exit,
  output logic             in_scc
);

  typedef enum logic {OUT = 1'b0, IN = 1'b1} state_t;

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NFAIR - 1);
  localparam logic [AGEW-1:0] AGE_MAX  = AGEW'(STARVE_LIMIT);

  state_t          state, state_nxt;
  logic [IDXW-1:0] idx_nxt;
  logic [CNTW-1:0] rounds_nxt;
  logic [AGEW-1:0] age, age_nxt, age_inc;
  logic            done_nxt, starve_nxt, exit_nxt;

  // fair padded to the full index range so fair_pad[idx] is always in range;
  // the pad bits never match since idx never exceeds NFAIR-1.
  logic [2**IDXW-1:0] fair_pad;
  always_comb begin
    fair_pad              = '0;
    fair_pad[NFAIR-1:0]   = fair;
  end

  // age saturates at the limit so starve holds without extra state
  assign age_inc = (age == AGE_MAX) ? age : age + AGEW'(1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= OUT;
      idx        <= '0;
      round_done <= 1'b0;
      rounds     <= '0;
      starve     <= 1'b0;
      scc_exit   <= 1'b0;
      age        <= '0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      round_done <= done_nxt;
      rounds     <= rounds_nxt;
      starve     <= starve_nxt;
      scc_exit   <= exit_nxt;
      age        <= age_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    done_nxt   = 1'b0;
    rounds_nxt = rounds;
    starve_nxt = starve;
    exit_nxt   = scc_exit;
    age_nxt    = age;
    if (step) begin
      state_nxt = scc ? IN : OUT;
      if (!scc) begin
        idx_nxt    = '0;
        age_nxt    = '0;
        starve_nxt = 1'b0;
        if (state == IN) exit_nxt = 1'b1;
      end else if (fair_pad[idx] && idx == LAST_IDX) begin
        idx_nxt    = '0;
        done_nxt   = 1'b1;
        age_nxt    = '0;
        starve_nxt = 1'b0;
        if (rounds != '1) rounds_nxt = rounds + CNTW'(1);
      end else begin
        if (fair_pad[idx]) idx_nxt = idx + IDXW'(1);
        age_nxt = age_inc;
        if (age_inc == AGE_MAX) starve_nxt = 1'b1;
      end
    end
  end

  assign in_scc = (state == IN);

endmodule

// File: tb/tb_fair_round_monitor.sv
module tb_fair_round_monitor;
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       step  = 1'b0;
  logic       scc   = 1'b0;
  logic [3:0] fair  = 4'd0;

  logic [1:0] idx_a, idx_b;
  logic [7:0] rounds_a;
  logic [1:0] rounds_b;
  logic       done_a, done_b, starve_a, starve_b, exit_a, exit_b, in_a, in_b;

  int checks = 0;
  int fails  = 0;

  // reference model state (shared by both instances except the counter width)
  int m_idx, m_age, m_rounds, m_rounds2;
  bit m_in, m_done, m_starve, m_exit;

  always #5 clock = ~clock;

  fair_round_monitor #(.NFAIR(4), .IDXW(2), .CNTW(8), .AGEW(7), .STARVE_LIMIT(64)) dut (
    .clock(clock), .reset(reset), .step(step), .scc(scc), .fair(fair),
    .idx(idx_a), .round_done(done_a), .rounds(rounds_a), .starve(starve_a),
    .scc_exit(exit_a), .in_scc(in_a));

  fair_round_monitor #(.NFAIR(4), .IDXW(2), .CNTW(2), .AGEW(7), .STARVE_LIMIT(64)) dut2 (
    .clock(clock), .reset(reset), .step(step), .scc(scc), .fair(fair),
    .idx(idx_b), .round_done(done_b), .rounds(rounds_b), .starve(starve_b),
    .scc_exit(exit_b), .in_scc(in_b));

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".idx"},        int'(idx_a),    m_idx);
    chk({tag, ".round_done"}, int'(done_a),   int'(m_done));
    chk({tag, ".rounds"},     int'(rounds_a), m_rounds);
    chk({tag, ".starve"},     int'(starve_a), int'(m_starve));
    chk({tag, ".scc_exit"},   int'(exit_a),   int'(m_exit));
    chk({tag, ".in_scc"},     int'(in_a),     int'(m_in));
    chk({tag, ".b.idx"},      int'(idx_b),    m_idx);
    chk({tag, ".b.rounds"},   int'(rounds_b), m_rounds2);
    chk({tag, ".b.starve"},   int'(starve_b), int'(m_starve));
    chk({tag, ".b.done"},     int'(done_b),   int'(m_done));
    chk({tag, ".b.exit"},     int'(exit_b),   int'(m_exit));
    chk({tag, ".b.in_scc"},   int'(in_b),     int'(m_in));
  endtask

  function automatic void model_reset();
    m_idx = 0; m_age = 0; m_rounds = 0; m_rounds2 = 0;
    m_in = 0; m_done = 0; m_starve = 0; m_exit = 0;
  endfunction

  // One sampling edge described by the round rules: wait for the sets in
  // order, count a round at the last one, age every other in-SCC cycle.
  function automatic void model_edge(input bit st, input bit s, input logic [3:0] f);
    if (!st) begin
      m_done = 0;
      return;
    end
    m_done = 0;
    if (!s) begin
      if (m_in) m_exit = 1;
      m_idx = 0; m_age = 0; m_starve = 0;
    end else if (f[m_idx] && m_idx == 3) begin
      m_idx = 0; m_age = 0; m_starve = 0; m_done = 1;
      m_rounds  = (m_rounds  < 255) ? m_rounds  + 1 : 255;
      m_rounds2 = (m_rounds2 < 3)   ? m_rounds2 + 1 : 3;
    end else begin
      if (f[m_idx]) m_idx = m_idx + 1;
      m_age = (m_age < 64) ? m_age + 1 : 64;
      if (m_age >= 64) m_starve = 1;
    end
    m_in = s;
  endfunction

  // drive, take one edge, update model, check 1 time unit after the edge
  task automatic cyc(input bit st, input bit s, input logic [3:0] f, input string tag);
    step = st; scc = s; fair = f;
    @(posedge clock);
    model_edge(st, s, f);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  initial begin
    model_reset();
    do_reset();
    check_all("reset");

    // T2 in-order pass
    cyc(1, 1, 4'b0001, "t2.e1");
    cyc(1, 1, 4'b0010, "t2.e2");
    cyc(1, 1, 4'b0100, "t2.e3");
    cyc(1, 1, 4'b1000, "t2.e4");
    chk("t2.pulse", int'(done_a), 1);
    chk("t2.rounds", int'(rounds_a), 1);
    cyc(1, 1, 4'b0000, "t2.after");
    chk("t2.pulse_one_cycle", int'(done_a), 0);

    // T3 ordering: all bits high advance one index per edge
    do_reset();
    for (int i = 0; i < 8; i++) cyc(1, 1, 4'b1111, "t3.all");
    chk("t3.rounds", int'(rounds_a), 2);
    for (int i = 0; i < 6; i++) cyc(1, 1, 4'b1000, "t3.only3");
    chk("t3.idx_stuck", int'(idx_a), 0);
    chk("t3.rounds_stuck", int'(rounds_a), 2);

    // T4 starvation
    do_reset();
    for (int i = 0; i < 63; i++) cyc(1, 1, 4'b0000, "t4.wait");
    chk("t4.not_yet", int'(starve_a), 0);
    cyc(1, 1, 4'b0000, "t4.e64");
    chk("t4.starve", int'(starve_a), 1);
    for (int i = 0; i < 5; i++) cyc(1, 1, 4'b0000, "t4.hold");
    cyc(1, 1, 4'b0001, "t4.r1");
    cyc(1, 1, 4'b0010, "t4.r2");
    cyc(1, 1, 4'b0100, "t4.r3");
    chk("t4.still", int'(starve_a), 1);
    cyc(1, 1, 4'b1000, "t4.r4");
    chk("t4.cleared", int'(starve_a), 0);

    // T5 exit with idx=2
    do_reset();
    cyc(1, 1, 4'b0001, "t5.a");
    cyc(1, 1, 4'b0010, "t5.b");
    chk("t5.idx2", int'(idx_a), 2);
    cyc(1, 0, 4'b0100, "t5.exit");
    chk("t5.exit", int'(exit_a), 1);
    cyc(1, 1, 4'b0001, "t5.reenter");
    chk("t5.sticky", int'(exit_a), 1);

    // T6 step gating right after a completion, then saturation
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1, 1, 4'b1111, "t6.round");
    cyc(1, 1, 4'b0001, "t6.mid");
    cyc(1, 1, 4'b1000, "t6.mid2");
    for (int i = 0; i < 10; i++) cyc(0, 1, 4'b1111, "t6.gated");
    chk("t6.idx_held", int'(idx_a), 1);
    for (int i = 0; i < 18; i++) cyc(1, 1, 4'b1111, "t6.sat");
    chk("t6.rounds8", int'(rounds_a), 5);
    chk("t6.rounds2_sat", int'(rounds_b), 3);
    cyc(1, 1, 4'b1111, "t6.done_then");
    cyc(0, 1, 4'b1111, "t6.done_clear");
    chk("t6.done_cleared_by_gate", int'(done_a), 0);

    // T1 asynchronous reset mid-round (idx=2, rounds=5)
    do_reset();
    for (int i = 0; i < 20; i++) cyc(1, 1, 4'b1111, "t1.fill");
    cyc(1, 1, 4'b0001, "t1.i1");
    cyc(1, 1, 4'b0010, "t1.i2");
    chk("t1.pre_idx", int'(idx_a), 2);
    chk("t1.pre_rounds", int'(rounds_a), 5);
    #2 reset = 1'b1;
    model_reset();
    #1 check_all("t1.async");
    #2 reset = 1'b0;

    // randomized run against the model
    for (int i = 0; i < 600; i++) begin
      bit st, s;
      logic [3:0] f;
      st = ($urandom_range(0, 9) != 0);
      s  = ($urandom_range(0, 19) != 0);
      f  = 4'($urandom);
      if ($urandom_range(0, 3) == 0) f = 4'b0000;
      cyc(st, s, f, "rand");
      if (i == 300) begin
        do_reset();
        check_all("rand.reset");
      end
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
